// File: rtl/gpio_rmw_master.sv
// Bus initiator for the GPIO register bus: READ/WRITE/SET/CLEAR/TOGGLE with read-modify-write bit ops.
// Optional write readback check enabled by defining GPIO_RMW_VERIFY_EN.
module gpio_rmw_master #(
  parameter int unsigned WIDTH        = 5,
  parameter logic [31:0] DATA_ADDR    = 32'h0000_0000,
  parameter logic [31:0] DIR_ADDR     = 32'h0000_0004,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic             cmd_sel_i,
  input  logic [WIDTH-1:0] cmd_mask_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             read_o,
  output logic             write_o,
  output logic [31:0]      address_o,
  output logic [31:0]      write_data_o,
  input  logic [31:0]      read_data_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_VFY_RD,
    S_VFY_WAIT,
    S_RSP
  } state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic             sel_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] old_c;
  logic [WIDTH-1:0] merged_c;
  logic [31:0]      sel_addr_c;
  logic             unused_rd_hi;

  function automatic logic [31:0] addr_of(input logic sel);
    return sel ? DIR_ADDR : DATA_ADDR;
  endfunction

  assign old_c        = read_data_i[WIDTH-1:0];
  assign sel_addr_c   = addr_of(sel_q);
  assign unused_rd_hi = ^read_data_i[31:WIDTH];

  // Bit-op merge of the value just read back from the register
  always_comb begin
    merged_c = old_c;
    case (op_q)
      OP_SET:    merged_c = old_c | mask_q;
      OP_CLEAR:  merged_c = old_c & ~mask_q;
      OP_TOGGLE: merged_c = old_c ^ mask_q;
      default:   merged_c = old_c;
    endcase
  end

  // Sequencer: outputs are registered together with the state they belong to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      sel_q        <= 1'b0;
      mask_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cmd_ready_o  <= 1'b0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      address_o    <= '0;
      write_data_o <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      cmd_ready_o  <= 1'b0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      address_o    <= '0;
      write_data_o <= '0;
      rsp_valid_o  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // cmd_ready_o is low for one cycle after reset release, so nothing is accepted then
          if (cmd_valid_i && cmd_ready_o) begin
            op_q   <= cmd_op_i;
            sel_q  <= cmd_sel_i;
            mask_q <= cmd_mask_i;
            case (cmd_op_i)
              OP_READ, OP_SET, OP_CLEAR, OP_TOGGLE: begin
                state_q   <= S_RD;
                read_o    <= 1'b1;
                address_o <= addr_of(cmd_sel_i);
              end
              OP_WRITE: begin
                state_q      <= S_WR;
                write_o      <= 1'b1;
                address_o    <= addr_of(cmd_sel_i);
                write_data_o <= 32'(cmd_data_i);
                wdata_q      <= cmd_data_i;
              end
              default: begin
                state_q     <= S_RSP;
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= '0;
                rsp_err_o   <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end

        S_RD: begin
          state_q <= S_RD_WAIT;
          cnt_q   <= CNT_W'(READ_LATENCY - 1);
        end

        S_RD_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (op_q == OP_READ) begin
            state_q     <= S_RSP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= old_c;
            rsp_err_o   <= 1'b0;
          end else begin
            state_q      <= S_WR;
            write_o      <= 1'b1;
            address_o    <= sel_addr_c;
            write_data_o <= 32'(merged_c);
            wdata_q      <= merged_c;
          end
        end

        S_WR: begin
`ifdef GPIO_RMW_VERIFY_EN
          state_q   <= S_VFY_RD;
          read_o    <= 1'b1;
          address_o <= sel_addr_c;
`else
          state_q     <= S_RSP;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= wdata_q;
          rsp_err_o   <= 1'b0;
`endif
        end

`ifdef GPIO_RMW_VERIFY_EN
        S_VFY_RD: begin
          state_q <= S_VFY_WAIT;
          cnt_q   <= CNT_W'(READ_LATENCY - 1);
        end

        // Readback compare; response still reports the value that was written
        S_VFY_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q     <= S_RSP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= wdata_q;
            rsp_err_o   <= (old_c != wdata_q);
          end
        end
`endif

        S_RSP: begin
          state_q     <= S_IDLE;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_rmw_master.sv
// Scoreboard bench for gpio_rmw_master: driver queues expected bus strobes and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_gpio_rmw_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic        cmd_sel = 1'b0;
  logic [4:0]  cmd_mask = 5'd0;
  logic [4:0]  cmd_data = 5'd0;
  logic        rd;
  logic        wr;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data = 32'd0;
  logic        rsp_valid;
  logic [4:0]  rsp_data;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          kind;   // 0 read strobe, 1 write strobe, 2 response
    int          at;     // clock edge at which the event is sampled
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rdata;
    logic        err;
    logic        chk_data;
  } ev_t;

  ev_t exp_q[$];

  gpio_rmw_master dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_sel_i    (cmd_sel),
    .cmd_mask_i   (cmd_mask),
    .cmd_data_i   (cmd_data),
    .read_o       (rd),
    .write_o      (wr),
    .address_o    (address),
    .write_data_o (write_data),
    .read_data_i  (read_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rdata, input logic err, input logic chk_data);
    ev_t e;
    e.kind = kind; e.at = at; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d got=present exp=none (cyc %0d)", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 32'(kind), 32'(e.kind));
    check("ev_cycle", 32'(cyc + 1), 32'(e.at));
    if (kind == 2) begin
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      if (e.chk_data) check("rsp_data", 32'(rsp_data), 32'(e.rdata));
    end else begin
      check("bus_address", address, e.addr);
      if (kind == 1) check("write_data", write_data, e.wdata);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rd_wr_exclusive", 32'(rd & wr), 32'd0);
      if (rd) take(0);
      if (wr) take(1);
      if (rsp_valid) take(2);
      if (!rd && !wr) begin
        check("idle_address", address, 32'd0);
        check("idle_write_data", write_data, 32'd0);
      end
    end
  end

  // Driver: rel < 0 means the event is not expected
  task automatic send(input logic [2:0] op, input logic sel, input logic [4:0] mask, input logic [4:0] data,
                      input logic [31:0] rdata, input int rd_rel, input int wr_rel, input int vr_rel,
                      input int rsp_rel, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                      input logic [4:0] exp_rsp, input logic exp_err, input logic chk_data,
                      input logic wait_done, output int acc);
    int n;
    @(negedge clk);
    read_data = rdata;
    cmd_op = op; cmd_sel = sel; cmd_mask = mask; cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout op=%0d got=not_accepted exp=accepted", op);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (rd_rel >= 0) push(0, acc + rd_rel, exp_addr, 32'd0, 5'd0, 1'b0, 1'b0);
    if (wr_rel >= 0) push(1, acc + wr_rel, exp_addr, exp_wdata, 5'd0, 1'b0, 1'b0);
    if (vr_rel >= 0) push(0, acc + vr_rel, exp_addr, 32'd0, 5'd0, 1'b0, 1'b0);
    push(2, acc + rsp_rel, 32'd0, 32'd0, exp_rsp, exp_err, chk_data);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL response_timeout op=%0d got=%0d_pending exp=0_pending", op, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  initial begin
    int a, b;
    rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_read", 32'(rd), 32'd0);
    check("rst_write", 32'(wr), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

`ifndef GPIO_RMW_VERIFY_EN
    // WRITE to direction register
    send(3'd1, 1'b1, 5'h00, 5'h15, 32'h0, -1, 1, -1, 2, 32'h4, 32'h15, 5'h15, 1'b0, 1'b1, 1'b1, a);
    @(negedge clk);
    check("rsp_data_hold", 32'(rsp_data), 32'h15);
    check("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    // SET / CLEAR / TOGGLE
    send(3'd2, 1'b0, 5'h12, 5'h00, 32'h05, 1, 3, -1, 4, 32'h0, 32'h17, 5'h17, 1'b0, 1'b1, 1'b1, a);
    send(3'd3, 1'b0, 5'h0A, 5'h00, 32'h1F, 1, 3, -1, 4, 32'h0, 32'h15, 5'h15, 1'b0, 1'b1, 1'b1, a);
    send(3'd4, 1'b1, 5'h03, 5'h00, 32'h15, 1, 3, -1, 4, 32'h4, 32'h16, 5'h16, 1'b0, 1'b1, 1'b1, a);
    // READ ignores upper read_data bits
    send(3'd0, 1'b1, 5'h00, 5'h00, 32'hFFFF_FFEA, 1, -1, -1, 3, 32'h4, 32'h0, 5'h0A, 1'b0, 1'b1, 1'b1, a);
    // Zero mask still writes back the unchanged value
    send(3'd2, 1'b0, 5'h00, 5'h00, 32'h09, 1, 3, -1, 4, 32'h0, 32'h09, 5'h09, 1'b0, 1'b1, 1'b1, a);
    // Illegal op held while busy is accepted only after the SET response
    send(3'd2, 1'b1, 5'h01, 5'h00, 32'h10, 1, 3, -1, 4, 32'h4, 32'h11, 5'h11, 1'b0, 1'b1, 1'b0, a);
    send(3'd6, 1'b0, 5'h00, 5'h00, 32'h10, -1, -1, -1, 1, 32'h0, 32'h0, 5'h00, 1'b1, 1'b0, 1'b1, b);
    check("held_accept_cycle", 32'(b - a), 32'd5);
    send(3'd7, 1'b1, 5'h1F, 5'h1F, 32'h0, -1, -1, -1, 1, 32'h0, 32'h0, 5'h00, 1'b1, 1'b0, 1'b1, a);
    // Asynchronous reset while waiting for read data
    send(3'd2, 1'b0, 5'h01, 5'h00, 32'h00, 1, 3, -1, 4, 32'h0, 32'h01, 5'h01, 1'b0, 1'b1, 1'b0, a);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_read", 32'(rd), 32'd0);
    check("midreset_write", 32'(wr), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 32'(cmd_ready), 32'd1);
    send(3'd0, 1'b0, 5'h00, 5'h00, 32'h0C, 1, -1, -1, 3, 32'h0, 32'h0, 5'h0C, 1'b0, 1'b1, 1'b1, a);
`else
    // Readback mismatch flags an error but reports the written value
    send(3'd1, 1'b0, 5'h00, 5'h1F, 32'h1E, -1, 1, 2, 4, 32'h0, 32'h1F, 5'h1F, 1'b1, 1'b1, 1'b1, a);
    send(3'd1, 1'b1, 5'h00, 5'h0A, 32'h0A, -1, 1, 2, 4, 32'h4, 32'h0A, 5'h0A, 1'b0, 1'b1, 1'b1, a);
    send(3'd2, 1'b0, 5'h12, 5'h00, 32'h05, 1, 3, 4, 6, 32'h0, 32'h17, 5'h17, 1'b1, 1'b1, 1'b1, a);
    send(3'd0, 1'b1, 5'h00, 5'h00, 32'h13, 1, -1, -1, 3, 32'h4, 32'h0, 5'h13, 1'b0, 1'b1, 1'b1, a);
    send(3'd5, 1'b0, 5'h00, 5'h00, 32'h0, -1, -1, -1, 1, 32'h0, 32'h0, 5'h00, 1'b1, 1'b0, 1'b1, a);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
